// File: rtl/cpu_seq_ctrl.sv
// Multi-cycle IF/ID/EX/MEM/WB sequencer with data-memory handshake and timeout.
// Define CPU_SEQ_INSTR_COUNT_EN to build the retired-instruction counter.
module cpu_seq_ctrl #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             step,
    input  logic [5:0]       op,
    input  logic             mem_ack,
    output logic             fetch_en,
    output logic             decode_en,
    output logic             alu_en,
    output logic             mem_req,
    output logic             mem_we,
    output logic             wb_en,
    output logic             pc_en,
    output logic [2:0]       state,
    output logic             halted,
    output logic             err,
    output logic [CNT_W-1:0] instr_cnt
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_IF   = 3'd1,
        S_ID   = 3'd2,
        S_EX   = 3'd3,
        S_MEM  = 3'd4,
        S_WB   = 3'd5,
        S_HALT = 3'd6,
        S_ERR  = 3'd7
    } state_t;

    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_HALT = 6'b111111;

    // last count value before expiry; the counter starts at 0 in the first MEM cycle
    localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

    state_t     st, st_nx, ret_st;
    logic [5:0] op_q;
    logic [7:0] tmo_q, tmo_nx;
    logic       is_lw, is_sw, no_wb;

    assign is_lw  = (op_q == OP_LW);
    assign is_sw  = (op_q == OP_SW);
    assign no_wb  = (op_q == OP_BEQ) || (op_q == OP_J);
    assign ret_st = run ? S_IF : S_IDLE;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st    <= S_IDLE;
            op_q  <= '0;
            tmo_q <= '0;
        end else begin
            st    <= st_nx;
            tmo_q <= tmo_nx;
            if (st == S_ID) op_q <= op;
        end
    end

    always_comb begin
        st_nx     = st;
        tmo_nx    = '0;
        fetch_en  = 1'b0;
        decode_en = 1'b0;
        alu_en    = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        wb_en     = 1'b0;
        pc_en     = 1'b0;
        unique case (st)
            S_IDLE: if (run || step) st_nx = S_IF;
            S_IF: begin
                fetch_en = 1'b1;
                st_nx    = S_ID;
            end
            S_ID: begin
                decode_en = 1'b1;
                st_nx     = (op == OP_HALT) ? S_HALT : S_EX;
            end
            S_EX: begin
                alu_en = 1'b1;
                st_nx  = (is_lw || is_sw) ? S_MEM : S_WB;
            end
            S_MEM: begin
                mem_req = 1'b1;
                mem_we  = is_sw;
                // an ack in the expiry cycle still completes the access
                if (mem_ack) begin
                    if (is_sw) begin
                        pc_en = 1'b1;
                        st_nx = ret_st;
                    end else begin
                        st_nx = S_WB;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    st_nx = S_ERR;
                end else begin
                    tmo_nx = tmo_q + 8'd1;
                end
            end
            S_WB: begin
                pc_en = 1'b1;
                wb_en = !no_wb;
                st_nx = ret_st;
            end
            S_HALT: st_nx = S_HALT;
            S_ERR:  st_nx = S_ERR;
        endcase
    end

    assign state  = st;
    assign halted = (st == S_HALT);
    assign err    = (st == S_ERR);

`ifdef CPU_SEQ_INSTR_COUNT_EN
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)       cnt_q <= '0;
        else if (pc_en) cnt_q <= cnt_q + 1'b1;
    end

    assign instr_cnt = cnt_q;
`else
    assign instr_cnt = '0;
`endif

endmodule

// File: doc/cpu_seq_ctrl.md
Name: cpu_seq_ctrl

Overview:
- Multi-cycle sequencer for the single-issue CPU datapath (fetch, decode, alu, memory, write stages).
- Walks one instruction at a time through IF, ID, EX, MEM and WB, and issues a one-cycle enable to each stage.
- Handles a req/ack handshake with data memory, with a timeout.
- Supports run and single-step modes, a HALT opcode and a sticky error state.

Parameters:
- MEM_TIMEOUT, 15: max cycles spent in MEM without mem_ack before entering ERR (1..255).
- CNT_W, 32: width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-low (0 = reset)
- run  in  1  level; 1 = free-running sequencing
- step  in  1  pulse; retire exactly one instruction when run=0 and in IDLE
- op  in  6  opcode from decode; sampled in ID
- mem_ack  in  1  data-memory completion; meaningful only in MEM
- fetch_en  out  1  IR/NPC load strobe
- decode_en  out  1  register-file read / immediate strobe
- alu_en  out  1  ALU result and address latch strobe
- mem_req  out  1  data-memory request, held until ack
- mem_we  out  1  1 = store, valid while mem_req=1
- wb_en  out  1  register-file write strobe
- pc_en  out  1  PC update strobe (one per retired instruction)
- state  out  3  current state encoding
- halted  out  1  sticky, HALT opcode executed
- err  out  1  sticky, memory timeout
- instr_cnt  out  CNT_W  retired-instruction count (see Optional Feature)

Behaviour:

State encoding: IDLE=0, IF=1, ID=2, EX=3, MEM=4, WB=5, HALT=6, ERR=7.
- state is registered.
- All strobes are decoded combinationally from state, op_q and mem_ack.

Reset (rst=0), effective immediately and asynchronously:
- state=IDLE.
- op_q=0, timeout counter=0, instr_cnt=0.
- All outputs 0; mem_req drops in the same instant, even mid-MEM.

Opcodes recognised from op_q:
- R-type 000000
- LW 100011
- SW 101011
- BEQ 000100
- J 000010
- HALT 111111
- Any other opcode is treated as ALU-immediate (writes back).

Transitions:
- IDLE: run=1 or step=1 -> IF; otherwise stay. All strobes 0.
- IF: fetch_en=1 -> ID.
- ID: decode_en=1; op_q<=op. op==HALT -> HALT, else -> EX.
- EX: alu_en=1. LW/SW -> MEM; all others -> WB.
- MEM: mem_req=1; mem_we=(op_q==SW). The timeout counter increments each cycle without ack.
  - mem_ack=1 and LW -> WB.
  - mem_ack=1 and SW -> retire; pc_en=1 in this ack cycle.
  - Counter reaches MEM_TIMEOUT without ack -> ERR.
  - The counter clears on leaving MEM.
- WB: pc_en=1; wb_en=1 only for R-type, LW and ALU-immediate (0 for BEQ and J) -> retire.
- Retire: next state is IF if run=1, else IDLE.
- HALT: halted=1, all strobes 0; held until reset.
- ERR: err=1, all strobes 0; held until reset.

Latency per instruction: 4 cycles for R/BEQ/J, 5+w cycles for LW, 4+w cycles for SW, where w = ack wait cycles (w>=0). The ack is accepted in the first MEM cycle if it is already high.

Boundary rules:
- run dropped mid-instruction: the current instruction completes, then IDLE.
- step is ignored outside IDLE; step with run=1 behaves as run.
- mem_ack outside MEM is ignored.
- An ack arriving in the cycle the timeout expires wins (completes the access, no ERR).
- pc_en asserts exactly once per retired instruction; never for HALT.
- At most one of fetch_en, decode_en, alu_en, mem_req, wb_en is high in any cycle.

Optional Feature:
- Macro: CPU_SEQ_INSTR_COUNT_EN.
- Defined: instr_cnt increments by 1 on every pc_en cycle and wraps modulo 2^CNT_W.
- Not defined: the counter register is not built and instr_cnt is tied to 0. The port remains.

Test Plan:
- Reset, run=1, op=000000 constant -> strobe sequence IF,ID,EX,WB repeats every 4 cycles; wb_en=1; pc_en=1 every 4th cycle.
- op=100011, mem_ack asserted 3 cycles after mem_req rises -> mem_req high 4 cycles with mem_we=0; WB follows with wb_en=1; 8-cycle instruction.
- op=101011, mem_ack tied 1 -> mem_we=1 for 1 cycle; pc_en in MEM cycle; no WB state; wb_en never 1.
- run=0, single step pulse, op=000100 -> exactly one IF..WB pass with wb_en=0, pc_en=1, then state=0; a second step pulse mid-pass is ignored.
- op=100011, mem_ack never asserted, MEM_TIMEOUT=15 -> ERR after 15 MEM cycles, err=1, mem_req=0. Asserting rst=0 mid-MEM in a separate run drops mem_req immediately with state=0.
- op=111111 after 5 R-type instructions -> halted=1, state=6, no further strobes. instr_cnt=5 with CPU_SEQ_INSTR_COUNT_EN defined, 0 without it.
